// File: rtl/uart_pkg.sv
// Shared receiver definitions: FSM state encoding, frame width and timing helpers.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int IDX_W     = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_state_t;

    // Offset from the first cycle of a bit to its sample point.
    function automatic int half_bit(input int cpb);
        return (cpb - 1) / 2;
    endfunction

    function automatic int cnt_width(input int cpb);
        return (cpb > 1) ? $clog2(cpb) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the serial line; both flops reset to the idle level.
// Latency: 2 cycles. No backpressure.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            dout <= 1'b1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver, samples each bit (CLKS_PER_BIT-1)/2 cycles into it; UART_RX_SYNC_EN adds an rx synchronizer.
// Latency: dataValid/frameError one cycle after the stop-bit sample (+2 cycles with UART_RX_SYNC_EN).
// No backpressure: each byte is presented for one cycle and must be captured then.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 dataValid,
    output logic                 frameError,
    output logic                 busy
);

    localparam int HALF = half_bit(CLKS_PER_BIT);
    localparam int CW   = cnt_width(CLKS_PER_BIT);

    localparam logic [CW-1:0]    BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]    HALF_LAST = (HALF > 0) ? CW'(HALF - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (rx),
        .dout (rx_s)
    );
`else
    assign rx_s = rx;
`endif

    uart_state_t          state;
    logic [CW-1:0]        cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;

    // cnt counts down to the next sample point; cnt == 0 marks a sample cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            rxData     <= '0;
            dataValid  <= 1'b0;
            frameError <= 1'b0;
            busy       <= 1'b0;
        end else begin
            dataValid  <= 1'b0;
            frameError <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        busy <= 1'b1;
                        idx  <= '0;
                        // With HALF == 0 the detection cycle is itself the start sample.
                        if (HALF == 0) begin
                            state <= DATA;
                            cnt   <= BIT_LAST;
                        end else begin
                            state <= START;
                            cnt   <= HALF_LAST;
                        end
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= DATA;
                        cnt   <= BIT_LAST;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        shreg[idx] <= rx_s;
                        cnt        <= BIT_LAST;
                        if (idx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        cnt <= '0;
                        if (rx_s) begin
                            rxData    <= shreg;
                            dataValid <= 1'b1;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            frameError <= 1'b1;
                            state      <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a frame table on a CLKS_PER_BIT=1 instance plus hand sequences
// (false start, framing error hold, mid-frame reset, loopback) on CLKS_PER_BIT=1/16 instances.
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rx1, rx16;
    logic [7:0] rxdata1, rxdata16;
    logic       dv1, fe1, busy1, dv16, fe16, busy16;

    uart_rx #(.CLKS_PER_BIT(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx1),
        .rxData     (rxdata1),
        .dataValid  (dv1),
        .frameError (fe1),
        .busy       (busy1)
    );

    uart_rx #(.CLKS_PER_BIT(16)) dut16 (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx16),
        .rxData     (rxdata16),
        .dataValid  (dv16),
        .frameError (fe16),
        .busy       (busy16)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse log: cycle stamp and rxData seen during each pulse.
    int         dv1_cyc[$];
    int         fe1_cyc[$];
    int         dv16_cyc[$];
    logic [7:0] dv1_dat[$];
    logic [7:0] fe1_dat[$];
    logic [7:0] dv16_dat[$];
    int         fe16_n = 0;
    int         both_n = 0;

    always @(negedge clk) begin
        if (dv1 === 1'b1) begin
            dv1_cyc.push_back(cyc);
            dv1_dat.push_back(rxdata1);
        end
        if (fe1 === 1'b1) begin
            fe1_cyc.push_back(cyc);
            fe1_dat.push_back(rxdata1);
        end
        if (dv16 === 1'b1) begin
            dv16_cyc.push_back(cyc);
            dv16_dat.push_back(rxdata16);
        end
        if (fe16 === 1'b1) fe16_n++;
        if ((dv1 === 1'b1 && fe1 === 1'b1) || (dv16 === 1'b1 && fe16 === 1'b1)) both_n++;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         idle;
        logic       exp_dv;
        logic [7:0] exp_rx;
    } vec_t;

    localparam int NV = 7;
    vec_t tv[NV];
    int   st[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    // Transmitter model: start bit, 8 data bits LSB first, stop bit.
    task automatic tx_frame(input bit wide, input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (wide) rx16 = f[i];
            else      rx1  = f[i];
            repeat (wide ? 16 : 1) tick();
        end
    endtask

    initial begin
        int s, s2, dv_rd, fe_rd, n_dv, n_fe;

        tv[0] = '{8'hA5, 1'b1, 0, 1'b1, 8'hA5};
        tv[1] = '{8'h00, 1'b1, 0, 1'b1, 8'h00};
        tv[2] = '{8'hFF, 1'b1, 3, 1'b1, 8'hFF};
        tv[3] = '{8'h3C, 1'b0, 3, 1'b0, 8'hFF};
        tv[4] = '{8'h81, 1'b1, 2, 1'b1, 8'h81};
        tv[5] = '{8'h6E, 1'b0, 2, 1'b0, 8'h81};
        tv[6] = '{8'h12, 1'b1, 0, 1'b1, 8'h12};

        rst  = 1'b1;
        rx1  = 1'b1;
        rx16 = 1'b1;
        repeat (2) tick();
        rx1 = 1'b0;
        tick();
        check("reset rxData1", rxdata1, 8'h00);
        check("reset dataValid1", dv1, 1'b0);
        check("reset frameError1", fe1, 1'b0);
        check("reset busy1", busy1, 1'b0);
        check("reset rxData16", rxdata16, 8'h00);
        check("reset dataValid16", dv16, 1'b0);
        check("reset frameError16", fe16, 1'b0);
        check("reset busy16", busy16, 1'b0);

        rst = 1'b0;
        rx1 = 1'b1;
        tick();
        check("no start from reset cycle", busy1, 1'b0);

        for (int i = 0; i < NV; i++) begin
            st[i] = cyc;
            tx_frame(1'b0, tv[i].data, tv[i].stop);
            rx1 = 1'b1;
            repeat (tv[i].idle) tick();
        end
        repeat (20) tick();

        dv_rd = 0;
        fe_rd = 0;
        for (int i = 0; i < NV; i++) begin
            if (tv[i].exp_dv) begin
                check($sformatf("v%0d dataValid pulse", i), dv1_cyc.size() > dv_rd, 1'b1);
                if (dv1_cyc.size() > dv_rd) begin
                    check($sformatf("v%0d dataValid cycle", i), dv1_cyc[dv_rd] - st[i], 10 + LAT);
                    check($sformatf("v%0d rxData", i), dv1_dat[dv_rd], tv[i].exp_rx);
                    dv_rd++;
                end
            end else begin
                check($sformatf("v%0d frameError pulse", i), fe1_cyc.size() > fe_rd, 1'b1);
                if (fe1_cyc.size() > fe_rd) begin
                    check($sformatf("v%0d frameError cycle", i), fe1_cyc[fe_rd] - st[i], 10 + LAT);
                    check($sformatf("v%0d rxData held", i), fe1_dat[fe_rd], tv[i].exp_rx);
                    fe_rd++;
                end
            end
        end
        check("table dataValid count", dv1_cyc.size(), dv_rd);
        check("table frameError count", fe1_cyc.size(), fe_rd);

        // Framing error with the line held low after the stop bit.
        n_dv = dv1_cyc.size();
        n_fe = fe1_cyc.size();
        s = cyc;
        tx_frame(1'b0, 8'h3C, 1'b0);
        rx1 = 1'b0;
        repeat (5) tick();
        rx1 = 1'b1;
        wait_cyc(s + 15 + LAT);
        check("wait_high busy while low", busy1, 1'b1);
        check("wait_high rxData held", rxdata1, 8'h12);
        tick();
        check("wait_high busy after rx high", busy1, 1'b0);
        repeat (20) tick();
        check("ferr pulse count", fe1_cyc.size(), n_fe + 1);
        if (fe1_cyc.size() > n_fe) begin
            check("ferr pulse cycle", fe1_cyc[n_fe] - s, 10 + LAT);
        end
        check("ferr no dataValid", dv1_cyc.size(), n_dv);

        // False start on the 16-clock instance.
        s = cyc;
        rx16 = 1'b0;
        repeat (4) tick();
        rx16 = 1'b1;
        wait_cyc(s + 7 + LAT);
        check("false start busy at sample", busy16, 1'b1);
        tick();
        check("false start busy cleared", busy16, 1'b0);
        repeat (10) tick();
        check("false start dataValid count", dv16_cyc.size(), 0);
        check("false start frameError count", fe16_n, 0);

        // Reset during data bit 4, then a clean frame.
        n_dv = dv1_cyc.size();
        rx1 = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            rx1 = (8'hC3 >> i) & 8'h01;
            tick();
        end
        rx1 = 1'b0;
        rst = 1'b1;
        tick();
        check("midframe reset rxData", rxdata1, 8'h00);
        check("midframe reset dataValid", dv1, 1'b0);
        check("midframe reset frameError", fe1, 1'b0);
        check("midframe reset busy", busy1, 1'b0);
        rst = 1'b0;
        rx1 = 1'b1;
        tick();
        s2 = cyc;
        tx_frame(1'b0, 8'h5A, 1'b1);
        rx1 = 1'b1;
        repeat (15) tick();
        check("post reset dataValid count", dv1_cyc.size(), n_dv + 1);
        if (dv1_cyc.size() > n_dv) begin
            check("post reset dataValid cycle", dv1_cyc[n_dv] - s2, 10 + LAT);
            check("post reset rxData", dv1_dat[n_dv], 8'h5A);
        end

        // Transmitter loopback at 16 clocks per bit.
        s = cyc;
        tx_frame(1'b1, 8'hC3, 1'b1);
        rx16 = 1'b1;
        repeat (20) tick();
        check("loopback dataValid count", dv16_cyc.size(), 1);
        if (dv16_cyc.size() > 0) begin
            check("loopback dataValid cycle", dv16_cyc[0] - s, 9 * 16 + 7 + 1 + LAT);
            check("loopback rxData", dv16_dat[0], 8'hC3);
        end
        check("loopback frameError count", fe16_n, 0);
        check("dataValid and frameError together", both_n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1, meaning clock cycles per serial bit (integer, >=1).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rx  input  1  serial line; idles high.
REQ-005 SHALL have port rxData  output  8  last correctly framed byte.
REQ-006 SHALL have port dataValid  output  1  one-cycle pulse marking a new rxData.
REQ-007 SHALL have port frameError  output  1  one-cycle pulse marking a stop bit sampled low.
REQ-008 SHALL have port busy  output  1  high whenever the block is not in IDLE.

Function
REQ-009 SHALL decode frames of 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), with no parity; this is the frame the team's transmitter emits.
REQ-010 SHALL use states IDLE, START, DATA, STOP and WAIT_HIGH, plus a bit-clock counter (0..CLKS_PER_BIT-1) and a bit index (0..7).
REQ-011 SHALL define HALF = (CLKS_PER_BIT-1)/2 (integer division); every bit is sampled HALF cycles after its first cycle.
REQ-012 SHALL treat the first IDLE cycle with rx=0 as cycle 0 of the start bit and enter START; if HALF=0, this same cycle is the start sample.
REQ-013 SHALL abort to IDLE from START if rx=1 at the start sample (false start), with no output pulse; if rx=0, go to DATA.
REQ-014 SHALL sample data bit i at cycle (i+1)*CLKS_PER_BIT+HALF after detection and shift it into bit position i.
REQ-015 SHALL sample the stop bit at cycle 9*CLKS_PER_BIT+HALF; if rx=1, the next cycle SHALL load rxData and pulse dataValid for exactly one cycle.
REQ-016 SHALL leave the stop-bit state for IDLE directly after a good stop sample, so a start bit in the very next cycle is detected (back-to-back frames at CLKS_PER_BIT=1).
REQ-017 SHALL, on a stop sample of rx=0, pulse frameError for one cycle in the next cycle, leave rxData unchanged, suppress dataValid, and enter WAIT_HIGH.
REQ-018 SHALL stay in WAIT_HIGH while rx=0 and return to IDLE on the first cycle rx=1; no start detection occurs in WAIT_HIGH.
REQ-019 SHALL never assert dataValid and frameError in the same cycle.
REQ-020 SHALL hold rxData stable except during the dataValid cycle update.

Reset
REQ-021 SHALL, with rst=1 at any edge including mid-frame, force IDLE, counters=0, rxData=8'h00, dataValid=0, frameError=0, busy=0, and discard any partial byte.
REQ-022 SHALL detect a start bit no earlier than the first cycle after rst deasserts.

Configuration
REQ-023 SHALL, when macro UART_RX_SYNC_EN is defined, pass rx through a 2-flop synchronizer (both flops reset to 1); all timing in REQ-012..REQ-018 is then measured on the synchronized signal, adding 2 cycles of latency.
REQ-024 SHALL, without UART_RX_SYNC_EN, use rx directly with no added latency.

Structure
REQ-025 SHALL place the state typedef (IDLE, START, DATA, STOP, WAIT_HIGH) and the constant DATA_BITS=8 in shared package uart_pkg.
REQ-026 SHALL implement the synchronizer as sub-module uart_rx_sync, instantiated only under UART_RX_SYNC_EN.

Verification
REQ-027 SHALL cover this case: CLKS_PER_BIT=1, rx=0,1,0,1,0,0,1,0,1,1 -> rxData=8'hA5, and dataValid is high for exactly 1 cycle, 10 cycles after the start.
REQ-028 SHALL cover this case: CLKS_PER_BIT=1, frame 8'h00 followed immediately by frame 8'hFF -> two dataValid pulses 10 cycles apart, with rxData values 8'h00 then 8'hFF.
REQ-029 SHALL cover this case: frame 8'h3C with stop=0, rx held low 5 cycles, then high -> one frameError pulse, rxData keeps the prior value, busy stays high until rx=1.
REQ-030 SHALL cover this case: CLKS_PER_BIT=16, rx low for 4 cycles then high -> false start, no pulses, busy falls by cycle 8.
REQ-031 SHALL cover this case: rst pulsed during data bit 4 -> all outputs at reset values, and the next full frame 8'h5A decodes correctly.
REQ-032 SHALL cover this case: loopback of the team's transmitter tx into rx with send of 8'hC3 -> one dataValid pulse with rxData=8'hC3, run both with and without UART_RX_SYNC_EN.
